// File: rtl/wb_port_if.sv
// Writeback port bundle: W-stage request, MDU result stream,
// register-file write and hazard/stall outputs.
interface wb_port_if;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_result_src;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_read_data;
   logic [31:0] wb_pc_plus_4;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [31:0] pend_mask;
   logic        stall_pipe;

   modport master (
      output wb_valid, wb_reg_write, wb_rd, wb_result_src,
      output wb_alu_result, wb_read_data, wb_pc_plus_4,
      output mdu_valid, mdu_rd, mdu_data,
      input  mdu_ready, rf_we, rf_rd, rf_wdata,
      input  pend_mask, stall_pipe
   );

   modport slave (
      input  wb_valid, wb_reg_write, wb_rd, wb_result_src,
      input  wb_alu_result, wb_read_data, wb_pc_plus_4,
      input  mdu_valid, mdu_rd, mdu_data,
      output mdu_ready, rf_we, rf_rd, rf_wdata,
      output pend_mask, stall_pipe
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by the in-order W stage and a
// compacting FIFO of multiply/divide results.
module wb_port_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic      clk,
   input logic      rst_n,
   wb_port_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {NORMAL, FORCE_DRAIN} state_t;

   logic [4:0]    rd_q  [DEPTH];
   logic [31:0]   dat_q [DEPTH];
   logic [4:0]    rd_d  [DEPTH];
   logic [31:0]   dat_d [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    starve_q, starve_d;
   state_t        state_q, state_d;

   logic          pipe_wr, deq, enq;
   logic [31:0]   pipe_dat;
   int            n_keep, n_all;

   logic          rf_we_q;
   logic [4:0]    rf_rd_q;
   logic [31:0]   rf_wdata_q;
   logic [31:0]   pend;

   always_comb begin
      pipe_wr  = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != 5'd0);
      pipe_dat = bus.wb_result_src[1] ? bus.wb_pc_plus_4 :
                 bus.wb_result_src[0] ? bus.wb_read_data :
                                        bus.wb_alu_result;
      deq      = ~pipe_wr & (cnt_q != '0);
      enq      = bus.mdu_valid & bus.mdu_ready &
                 (bus.mdu_rd != 5'd0) &
                 ~(pipe_wr & (bus.mdu_rd == bus.wb_rd));
   end

   assign bus.mdu_ready = (cnt_q < CW'(DEPTH));

   // Survivors (not dequeued, not squashed) shift down to the head.
   always_comb begin
      rd_d   = rd_q;
      dat_d  = dat_q;
      n_keep = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(cnt_q) && !(deq && i == 0) &&
             !(pipe_wr && rd_q[i] == bus.wb_rd)) begin
            rd_d[AW'(n_keep)]  = rd_q[i];
            dat_d[AW'(n_keep)] = dat_q[i];
            n_keep = n_keep + 1;
         end
      end
      n_all = n_keep;
      if (enq) begin
         rd_d[AW'(n_keep)]  = bus.mdu_rd;
         dat_d[AW'(n_keep)] = bus.mdu_data;
         n_all = n_keep + 1;
      end
      cnt_d = CW'(n_all);
   end

   always_comb begin
      starve_d = 4'd0;
      if (pipe_wr && n_keep != 0) begin
         starve_d = (starve_q < 4'(STARVE_LIMIT)) ?
                    starve_q + 4'd1 : starve_q;
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(cnt_q)) pend[rd_q[i]] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         starve_q <= 4'd0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]  <= 5'd0;
            dat_q[i] <= 32'd0;
         end
      end else begin
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         rd_q     <= rd_d;
         dat_q    <= dat_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else begin
         rf_we_q <= pipe_wr | deq;
         if (pipe_wr) begin
            rf_rd_q    <= bus.wb_rd;
            rf_wdata_q <= pipe_dat;
         end else if (deq) begin
            rf_rd_q    <= rd_q[0];
            rf_wdata_q <= dat_q[0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= NORMAL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         NORMAL:
            if (starve_d == 4'(STARVE_LIMIT)) state_d = FORCE_DRAIN;
         FORCE_DRAIN:
            if (cnt_d == '0) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   always_comb begin
      bus.stall_pipe = (state_q == FORCE_DRAIN);
   end

   assign bus.rf_we     = rf_we_q;
   assign bus.rf_rd     = rf_rd_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.pend_mask = pend;
endmodule
